// File: rtl/majority_window_filter.sv
// Per-channel sliding-window vote filter: each channel keeps its last WINDOW accepted bits
// plus a running ones-count, and emits a registered majority/unanimity/threshold decision.
module majority_window_filter #(
  parameter int CHANNELS = 4,
  parameter int WINDOW   = 5,
  parameter int CW       = $clog2(WINDOW + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [CHANNELS-1:0] in_data,
  input  logic [1:0]          mode,
  input  logic [CW-1:0]       threshold,
  output logic                out_valid,
  output logic [CHANNELS-1:0] out_data,
  output logic                filled
);

  // Handshake: a sample is taken on every rising edge with in_valid=1 and clear=0; there is
  // no ready/backpressure, and out_valid is a single-cycle pulse with out_data valid in that cycle.

  typedef enum logic {
    FILLING = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam logic [CW-1:0] MAJ_LEVEL = CW'((WINDOW + 1) / 2);
  localparam logic [CW-1:0] WIN_FULL  = CW'(WINDOW);
  localparam logic [CW-1:0] FILL_LAST = CW'(WINDOW - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic [WINDOW-1:0]     win_q    [CHANNELS];
  logic [CW-1:0]         cnt_q    [CHANNELS];
  logic [CW-1:0]         cnt_next [CHANNELS];
  logic [CHANNELS-1:0]   vote;
  logic                  accept;

  assign accept = in_valid & ~clear;
  assign filled = (state_q == RUNNING);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (accept && state_q == FILLING) begin
      fill_d = fill_q + CW'(1);
      if (fill_q == FILL_LAST) state_d = RUNNING;
    end
  end

  // Subtract the departing bit before adding the new one so the count never exceeds WINDOW.
  always_comb begin
    vote = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_next[c] = cnt_q[c]
                  - CW'((state_q == RUNNING) ? win_q[c][WINDOW-1] : 1'b0)
                  + CW'(in_data[c]);
      case (mode)
        2'b01:   vote[c] = (cnt_next[c] == WIN_FULL);
        2'b10:   vote[c] = (cnt_next[c] >= threshold);
        default: vote[c] = (cnt_next[c] >= MAJ_LEVEL);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q   <= FILLING;
      fill_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        win_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      out_valid <= 1'b0;
      if (in_valid) begin
        for (int c = 0; c < CHANNELS; c++) begin
          win_q[c] <= {win_q[c][WINDOW-2:0], in_data[c]};
          cnt_q[c] <= cnt_next[c];
        end
        if (state_d == RUNNING) begin
          out_valid <= 1'b1;
          out_data  <= vote;
        end
      end
    end
  end

endmodule
